// File: rtl/bootram_pkg.sv
// Shared types and helpers for the parametrised boot RAM.
// Word width helper, controller state encoding, read-latency range.
package bootram_pkg;

    typedef enum logic {
        ST_FILL,
        ST_IDLE
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int word_w(input int lanes);
        return 8 * lanes;
    endfunction

endpackage

// File: rtl/bootram_gen_if.sv
// Memory bus between the b16 core and the boot RAM.
// master: sel/r/w/addr/din out; slave: dout/ack/ready/filling out.
interface bootram_gen_if #(
    parameter int LANES  = 2,
    parameter int ADDR_W = 12
);

    logic                 sel;
    logic                 r;
    logic [LANES-1:0]     w;
    logic [ADDR_W-1:0]    addr;
    logic [8*LANES-1:0]   din;
    logic [8*LANES-1:0]   dout;
    logic                 ack;
    logic                 ready;
    logic                 filling;

    modport master (
        output sel, r, w, addr, din,
        input  dout, ack, ready, filling
    );

    modport slave (
        input  sel, r, w, addr, din,
        output dout, ack, ready, filling
    );

endinterface

// File: rtl/bootram_array.sv
// Inferred single-address synchronous RAM, per-lane write enables.
// Ports: clk, we[LANES], re, addr, wdata in; q out (read-first, held).
module bootram_array #(
    parameter int LANES  = 2,
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic [LANES-1:0]     we,
    input  logic                 re,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [8*LANES-1:0]   wdata,
    output logic [8*LANES-1:0]   q
);

    logic [8*LANES-1:0] mem [2**ADDR_W];

    // Read and write share one block so a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (re) begin
            q <= mem[addr];
        end
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/bootram_gen.sv
// Boot RAM with post-reset fill engine, read pipeline and ack.
// Ports: clk, nreset (async, active low), bus (slave side of bootram_gen_if).
module bootram_gen
    import bootram_pkg::*;
#(
    parameter int                 LANES    = 2,
    parameter int                 ADDR_W   = 12,
    parameter int                 RD_LAT   = 1,
    parameter int                 FILL_EN  = 1,
    parameter logic [8*LANES-1:0] FILL_VAL = '0
) (
    input  logic         clk,
    input  logic         nreset,
    bootram_gen_if.slave bus
);

    localparam int                WORD_W    = word_w(LANES);
    localparam logic [ADDR_W-1:0] LAST_PTR  = '1;
    localparam state_t            RST_STATE = (FILL_EN != 0) ? ST_FILL : ST_IDLE;

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX || LANES < 1) begin : g_param_err
        $error("bootram_gen: RD_LAT must be 1 or 2 and LANES >= 1");
    end

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   fill_ptr_q;
    logic [LANES-1:0]    ram_we;
    logic                ram_re;
    logic [ADDR_W-1:0]   ram_addr;
    logic [WORD_W-1:0]   ram_wdata;
    logic [WORD_W-1:0]   ram_q;
    logic                wr_only;
    logic                rd_v1_q;
    logic                wr_ack_q;
    logic                ready;
    logic                filling;

    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        filling   = 1'b0;
        ram_we    = '0;
        ram_re    = 1'b0;
        ram_addr  = bus.addr;
        ram_wdata = bus.din;
        wr_only   = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                filling   = 1'b1;
                ram_we    = '1;
                ram_addr  = fill_ptr_q;
                ram_wdata = FILL_VAL;
                if (fill_ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.sel) begin
                    ram_re  = bus.r;
                    ram_we  = bus.w;
                    // Read+write acks once, at read latency.
                    wr_only = !bus.r && (|bus.w);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= RST_STATE;
            fill_ptr_q <= '0;
            rd_v1_q    <= 1'b0;
            wr_ack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_v1_q  <= ram_re;
            wr_ack_q <= wr_only;
            if (filling) begin
                fill_ptr_q <= fill_ptr_q + 1'b1;
            end
        end
    end

    bootram_array #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    if (RD_LAT == 1) begin : g_lat1
        // RAM output register is the data register; gate it to 0 until
        // the first read so dout has a defined reset value.
        logic have_q;

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                have_q <= 1'b0;
            end else if (ram_re) begin
                have_q <= 1'b1;
            end
        end

        assign bus.dout = have_q ? ram_q : '0;
        assign bus.ack  = rd_v1_q | wr_ack_q;
    end else begin : g_lat2
        logic              rd_v2_q;
        logic [WORD_W-1:0] dout_q;

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                rd_v2_q <= 1'b0;
                dout_q  <= '0;
            end else begin
                rd_v2_q <= rd_v1_q;
                if (rd_v1_q) begin
                    dout_q <= ram_q;
                end
            end
        end

        assign bus.dout = dout_q;
        assign bus.ack  = rd_v2_q | wr_ack_q;
    end

    assign bus.ready   = ready;
    assign bus.filling = filling;

endmodule
